// File: rtl/fft_ctrl_pkg.sv
// Shared types and default sizing for the FFT stream controller.
package fft_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WAIT,
      RD_REQ,
      RD_CAP,
      OUT
   } state_t;

   localparam int DEF_ADDR_WIDTH  = 5;
   localparam int DEF_DATA_WIDTH  = 16;
   localparam int DEF_DEPTH       = 32;
   localparam int DEF_WAIT_CYCLES = 64;

   // Settle counter must hold WAIT_CYCLES and never collapse to zero width.
   function automatic int wait_cnt_width(input int cycles);
      int w;
      w = $clog2(cycles + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/fft_stream_ctrl.sv
// Frame sequencer for the FFT wrapper: streams DEPTH samples into the
// wrapper write port, waits for the transform to settle, then reads the
// DEPTH complex results back out onto a valid/ready stream.
//
// state  | meaning
// IDLE   | no frame in flight, ready for the first sample
// LOAD   | accepting samples, writing each one to index wcnt
// WAIT   | settle down-counter running after the last write
// RD_REQ | read strobe for result index rcnt
// RD_CAP | read data arrives, captured into the output register
// OUT    | result presented downstream, held until accepted
module fft_stream_ctrl
   import fft_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int DEPTH       = DEF_DEPTH,
   parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [2*DATA_WIDTH-1:0] out_data,
   output logic                    out_last,
   output logic [ADDR_WIDTH-1:0]   m_addr,
   output logic [DATA_WIDTH-1:0]   m_data,
   output logic                    m_we,
   output logic [ADDR_WIDTH-1:0]   s_addr,
   output logic                    s_re,
   input  logic [2*DATA_WIDTH-1:0] s_data,
   output logic                    busy,
   output logic                    frame_done
);

   localparam int                    WW       = wait_cnt_width(WAIT_CYCLES);
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

   state_t                state;
   state_t                state_nxt;
   logic [ADDR_WIDTH-1:0] wcnt;
   logic [ADDR_WIDTH-1:0] rcnt;
   logic [WW-1:0]         wait_cnt;
   logic                  in_hs;
   logic                  out_hs;
   logic                  last_in;

   assign in_hs   = in_valid & in_ready;
   assign out_hs  = (state == OUT) & out_ready;
   assign last_in = (state == LOAD) & in_hs & (wcnt == LAST_IDX);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode; a zero settle time skips WAIT entirely.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = LOAD;
         LOAD:    if (last_in) state_nxt = (WAIT_CYCLES == 0) ? RD_REQ : WAIT;
         WAIT:    if (wait_cnt <= WW'(1)) state_nxt = RD_REQ;
         RD_REQ:  state_nxt = RD_CAP;
         RD_CAP:  state_nxt = OUT;
         OUT:     if (out_ready) state_nxt = (rcnt == LAST_IDX) ? IDLE : RD_REQ;
         default: state_nxt = IDLE;
      endcase
   end

   // State-decoded outputs.
   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b1;
      s_re     = 1'b0;
      s_addr   = rcnt;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
         end
         LOAD:    in_ready = 1'b1;
         RD_REQ:  s_re = 1'b1;
         default: ;
      endcase
   end

   // Counters, registered write port and the held output word.
   always_ff @(posedge clk) begin
      if (rst) begin
         wcnt       <= '0;
         rcnt       <= '0;
         wait_cnt   <= '0;
         m_we       <= 1'b0;
         m_addr     <= '0;
         m_data     <= '0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         m_we       <= in_hs;
         frame_done <= 1'b0;

         if (in_hs) begin
            m_addr <= wcnt;
            m_data <= in_data;
            wcnt   <= wcnt + ADDR_WIDTH'(1);
         end

         if (last_in)
            wait_cnt <= WW'(WAIT_CYCLES);
         else if (state == WAIT)
            wait_cnt <= wait_cnt - WW'(1);

         if (state == RD_CAP) begin
            out_data  <= s_data;
            out_valid <= 1'b1;
            out_last  <= (rcnt == LAST_IDX);
         end

         if (out_hs) begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            rcnt       <= rcnt + ADDR_WIDTH'(1);
            frame_done <= (rcnt == LAST_IDX);
         end
      end
   end

endmodule

// File: tb/tb_fft_stream_ctrl.sv
// Bench for fft_stream_ctrl: two instances (settle 4 and settle 0) driven by
// random/patterned streams, a wrapper memory model, and a frame-level
// reference model of the expected port behaviour.
`timescale 1ns/1ps
module tb_fft_stream_ctrl;

   localparam int AW = 5;
   localparam int DW = 16;
   localparam int N  = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]         rst;
   logic [1:0]         in_valid, in_ready, out_valid, out_ready, out_last;
   logic [1:0]         m_we, s_re, busy, frame_done;
   logic [1:0][DW-1:0] in_data, m_data;
   logic [1:0][2*DW-1:0] out_data, s_data;
   logic [1:0][AW-1:0] m_addr, s_addr;

   fft_stream_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(N), .WAIT_CYCLES(4)) u_dut_w4 (
      .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .out_last(out_last[0]),
      .m_addr(m_addr[0]), .m_data(m_data[0]), .m_we(m_we[0]), .s_addr(s_addr[0]), .s_re(s_re[0]),
      .s_data(s_data[0]), .busy(busy[0]), .frame_done(frame_done[0]));

   fft_stream_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(N), .WAIT_CYCLES(0)) u_dut_w0 (
      .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .out_last(out_last[1]),
      .m_addr(m_addr[1]), .m_data(m_data[1]), .m_we(m_we[1]), .s_addr(s_addr[1]), .s_re(s_re[1]),
      .s_data(s_data[1]), .busy(busy[1]), .frame_done(frame_done[1]));

   function automatic int wait_of(input int k);
      return (k == 0) ? 4 : 0;
   endfunction

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s inst=%0d cyc=%0d got=%0h want=%0h", nm, k, cyc, act, exp);
      end
   endtask

   // Wrapper model: plain memory; the "transform" of index i is {~x, x}.
   // Read data is only meaningful the cycle after s_re, otherwise noise.
   logic [DW-1:0] mem [2][N];
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (m_we[k]) mem[k][m_addr[k]] <= m_data[k];
         if (s_re[k]) s_data[k] <= {~mem[k][s_addr[k]], mem[k][s_addr[k]]};
         else         s_data[k] <= $urandom;
      end
   end

   // Reference model state (per instance).
   logic [DW-1:0] frame [2][N];
   int  acc_m [2], res_m [2], re_cyc [2], fd_cyc [2];
   bit  phase_out [2], pend_we [2], last_in_hs [2];
   logic [AW-1:0] pend_addr [2];
   logic [DW-1:0] pend_data [2];
   int  wr_cnt [2], hs_cnt [2], last_cnt [2], last_we [2], first_re [2];
   int  done_wr [2], done_hs [2], done_last [2], done_gap [2], frames_done [2];
   int  stall_obs [2];
   logic [2*DW-1:0] stall_ref [2];

   // Stimulus knobs.
   bit  in_en [2];
   int  iv_mode [2], or_mode [2], data_mode [2], stall_idx [2], stall_len [2], stall_drv [2], seq [2];
   bit  tog [2];

   task automatic model_reset(input int k);
      acc_m[k] = 0; res_m[k] = 0; re_cyc[k] = -1; fd_cyc[k] = -10;
      phase_out[k] = 0; pend_we[k] = 0; last_in_hs[k] = 0;
      wr_cnt[k] = 0; hs_cnt[k] = 0; last_cnt[k] = 0; last_we[k] = -1; first_re[k] = -1;
   endtask

   task automatic monitor(input int k);
      bit exp_re, exp_ov, hs_in;
      logic [2*DW-1:0] exp_out;
      if (rst[k]) begin
         model_reset(k);
         return;
      end
      chk("m_we", k, m_we[k], pend_we[k]);
      if (pend_we[k]) begin
         chk("m_addr", k, m_addr[k], pend_addr[k]);
         chk("m_data", k, m_data[k], pend_data[k]);
      end
      pend_we[k] = 0;
      chk("in_ready", k, in_ready[k], !phase_out[k]);
      chk("busy", k, busy[k], phase_out[k] || acc_m[k] != 0);
      chk("frame_done", k, frame_done[k], cyc == fd_cyc[k]);
      exp_re = (re_cyc[k] >= 0) && (cyc == re_cyc[k]);
      exp_ov = (re_cyc[k] >= 0) && (cyc >= re_cyc[k] + 2);
      chk("s_re", k, s_re[k], exp_re);
      if (exp_re) chk("s_addr", k, s_addr[k], res_m[k]);
      chk("out_valid", k, out_valid[k], exp_ov);
      exp_out = {~frame[k][res_m[k]], frame[k][res_m[k]]};
      if (exp_ov) begin
         chk("out_data", k, out_data[k], exp_out);
         chk("out_last", k, out_last[k], res_m[k] == N - 1);
      end else begin
         chk("out_last_idle", k, out_last[k], 0);
      end

      if (m_we[k]) begin wr_cnt[k]++; last_we[k] = cyc; end
      if (s_re[k] && first_re[k] < 0) first_re[k] = cyc;
      if (or_mode[k] == 1 && out_valid[k] && !out_ready[k] && res_m[k] == stall_idx[k]) begin
         if (stall_obs[k] == 0) stall_ref[k] = out_data[k];
         else chk("stall_hold", k, out_data[k], stall_ref[k]);
         chk("stall_no_re", k, s_re[k], 0);
         stall_obs[k]++;
      end

      hs_in = in_valid[k] && !phase_out[k];
      last_in_hs[k] = in_valid[k] && in_ready[k];
      if (hs_in) begin
         frame[k][acc_m[k]] = in_data[k];
         pend_we[k]   = 1;
         pend_addr[k] = AW'(acc_m[k]);
         pend_data[k] = in_data[k];
         acc_m[k]++;
         if (acc_m[k] == N) begin
            phase_out[k] = 1;
            re_cyc[k] = cyc + 1 + wait_of(k);
         end
      end
      if (exp_ov && out_ready[k]) begin
         hs_cnt[k]++;
         if (out_last[k]) last_cnt[k]++;
         res_m[k]++;
         if (res_m[k] == N) begin
            fd_cyc[k] = cyc + 1; phase_out[k] = 0; acc_m[k] = 0; res_m[k] = 0; re_cyc[k] = -1;
         end else begin
            re_cyc[k] = cyc + 1;
         end
      end
      if (frame_done[k]) begin
         done_wr[k] = wr_cnt[k]; done_hs[k] = hs_cnt[k]; done_last[k] = last_cnt[k];
         done_gap[k] = first_re[k] - last_we[k];
         frames_done[k]++;
         wr_cnt[k] = 0; hs_cnt[k] = 0; last_cnt[k] = 0; last_we[k] = -1; first_re[k] = -1;
      end
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) monitor(k);
      cyc++;
   end

   task automatic drive(input int k);
      if (last_in_hs[k]) seq[k]++;
      if (!in_en[k]) begin
         in_valid[k] = 1'b0;
      end else if (!(in_valid[k] && !last_in_hs[k])) begin
         case (iv_mode[k])
            0:       in_valid[k] = 1'b1;
            1:       begin in_valid[k] = tog[k]; tog[k] = !tog[k]; end
            default: in_valid[k] = 1'($urandom_range(0, 1));
         endcase
         in_data[k] = (data_mode[k] == 0) ? DW'(seq[k]) : DW'($urandom);
      end
      case (or_mode[k])
         0: out_ready[k] = 1'b1;
         1: if (out_valid[k] && res_m[k] == stall_idx[k] && stall_drv[k] < stall_len[k]) begin
               out_ready[k] = 1'b0;
               stall_drv[k]++;
            end else begin
               out_ready[k] = 1'b1;
            end
         default: out_ready[k] = 1'($urandom_range(0, 1));
      endcase
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         for (int k = 0; k < 2; k++) drive(k);
      end
   end

   typedef struct {
      int dut;
      int iv_mode;
      int or_mode;
      int data_mode;
      int stall_idx;
      int stall_len;
      int exp_gap;
      int exp_wr;
      int exp_hs;
      int exp_last;
   } scen_t;

   scen_t sc [7];

   initial begin
      int k, cnt, start;
      sc[0] = '{0, 0, 0, 0, 0,  0, 4, N, N, 1};  // back-to-back, samples 0..31
      sc[1] = '{0, 1, 0, 1, 0,  0, 4, N, N, 1};  // in_valid every other cycle, held into WAIT
      sc[2] = '{0, 0, 1, 1, 5, 10, 4, N, N, 1};  // 10-cycle stall at result 5
      sc[3] = '{1, 0, 0, 0, 0,  0, 0, N, N, 1};  // zero settle time
      sc[4] = '{0, 2, 2, 1, 0,  0, 4, N, N, 1};  // random both sides
      sc[5] = '{1, 2, 2, 1, 0,  0, 0, N, N, 1};  // random both sides, zero settle
      sc[6] = '{1, 1, 1, 1, 31, 3, 0, N, N, 1};  // stall on the last result

      rst = 2'b11;
      in_valid = '0; out_ready = '1; in_data = '0; s_data = '0;
      for (int j = 0; j < 2; j++) begin
         in_en[j] = 0; iv_mode[j] = 0; or_mode[j] = 0; data_mode[j] = 0;
         stall_idx[j] = 0; stall_len[j] = 0; stall_drv[j] = 0; seq[j] = 0; tog[j] = 0;
         stall_obs[j] = 0; frames_done[j] = 0;
         model_reset(j);
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 2'b00;

      for (int j = 0; j < 2; j++) begin
         chk("rst_in_ready", j, in_ready[j], 1);
         chk("rst_busy", j, busy[j], 0);
         chk("rst_out_valid", j, out_valid[j], 0);
         chk("rst_out_last", j, out_last[j], 0);
         chk("rst_m_we", j, m_we[j], 0);
         chk("rst_s_re", j, s_re[j], 0);
         chk("rst_frame_done", j, frame_done[j], 0);
         chk("rst_out_data", j, out_data[j], 0);
         chk("rst_m_addr", j, m_addr[j], 0);
         chk("rst_m_data", j, m_data[j], 0);
         chk("rst_s_addr", j, s_addr[j], 0);
      end

      for (int i = 0; i < 7; i++) begin
         k = sc[i].dut;
         iv_mode[k] = sc[i].iv_mode; or_mode[k] = sc[i].or_mode; data_mode[k] = sc[i].data_mode;
         stall_idx[k] = sc[i].stall_idx; stall_len[k] = sc[i].stall_len;
         stall_drv[k] = 0; stall_obs[k] = 0; seq[k] = 0; tog[k] = 1;
         start = frames_done[k];
         in_en[k] = 1;
         cnt = 0;
         while (frames_done[k] == start && cnt < 3000) begin
            @(posedge clk);
            cnt++;
         end
         in_en[k] = 0;
         chk("frame_timeout", k, cnt < 3000, 1);
         chk("writes", k, done_wr[k], sc[i].exp_wr);
         chk("results", k, done_hs[k], sc[i].exp_hs);
         chk("last_count", k, done_last[k], sc[i].exp_last);
         chk("wr_rd_gap", k, done_gap[k], sc[i].exp_gap);
         if (sc[i].or_mode == 1) chk("stall_cycles", k, stall_obs[k], sc[i].stall_len);
      end

      // Mid-frame reset on the settle-4 instance, then a full clean frame.
      iv_mode[0] = 0; or_mode[0] = 0; data_mode[0] = 0; seq[0] = 0;
      in_en[0] = 1;
      cnt = 0;
      while (acc_m[0] < 17 && cnt < 500) begin
         @(posedge clk);
         cnt++;
      end
      chk("reach_17", 0, cnt < 500, 1);
      #1;
      rst[0] = 1'b1;
      @(posedge clk);
      #1;
      rst[0] = 1'b0;
      start = frames_done[0];
      cnt = 0;
      do begin
         @(posedge clk);
         #2;
         cnt++;
      end while (!m_we[0] && cnt < 100);
      chk("post_rst_first_we", 0, m_we[0], 1);
      chk("post_rst_addr", 0, m_addr[0], 0);
      cnt = 0;
      while (frames_done[0] == start && cnt < 3000) begin
         @(posedge clk);
         cnt++;
      end
      in_en[0] = 0;
      chk("post_rst_timeout", 0, cnt < 3000, 1);
      chk("post_rst_writes", 0, done_wr[0], N);
      chk("post_rst_results", 0, done_hs[0], N);
      chk("post_rst_last", 0, done_last[0], 1);

      repeat (5) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
